// File: rtl/resv_exec_pkg.sv
// Shared encodings for the integer execute stage: micro-op classes, function codes,
// the bubble encoding and the sequencing FSM states.
package resv_exec_pkg;

    localparam logic [2:0] CLS_ALUI = 3'b000;
    localparam logic [2:0] CLS_ALUR = 3'b001;
    localparam logic [2:0] CLS_MUL  = 3'b010;

    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_SUB = 3'd1;
    localparam logic [2:0] FN_AND = 3'd2;
    localparam logic [2:0] FN_OR  = 3'd3;
    localparam logic [2:0] FN_XOR = 3'd4;
    localparam logic [2:0] FN_SLL = 3'd5;
    localparam logic [2:0] FN_SRL = 3'd6;
    localparam logic [2:0] FN_SLT = 3'd7;

    localparam logic [2:0] FN_MUL_LO = 3'd0;
    localparam logic [2:0] FN_MUL_HI = 3'd1;

    localparam logic [5:0] unused_op = 6'h3F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } exec_state_t;

endpackage

// File: rtl/resv_exec_unit_iter_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, LSB first.
// done pulses during the final step; product then already includes that step.
module iter_mul #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_next;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  count;
    logic           running;

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (start) begin
            mcand   <= {{W{1'b0}}, a};
            mplier  <= b;
            acc     <= '0;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (count == CW'(W - 1)) begin
                running <= 1'b0;
            end
        end
    end

    always_comb begin
        done    = running && (count == CW'(W - 1));
        product = acc_next;
    end

endmodule

// File: rtl/resv_exec_unit.sv
// Integer execute stage behind the reservation station: single-cycle ALU inline,
// multiplies on the iterative engine, all results broadcast on the update bus.
module resv_exec_unit #(
    parameter int W_PD_UOPS  = 6,
    parameter int W_PD_DATA  = 32,
    parameter int W_PA_REG   = 5,
    parameter int W_AA_INSTR = 32,
    parameter logic [W_PD_UOPS-1:0] unused_op = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  DFI_PC_valid,
    input  logic [W_PD_UOPS-1:0]  DFI_PD_uops,
    input  logic [W_PD_DATA-1:0]  DFI_PD_rs,
    input  logic [W_PD_DATA-1:0]  DFI_PD_rt,
    input  logic [W_PD_DATA-1:0]  DFI_PD_imm,
    input  logic [W_PA_REG-1:0]   DFI_PA_rd,
    input  logic [W_AA_INSTR-1:0] DFI_AA_pc,
    input  logic                  CFI_PC_clear,
    output logic                  CFO_PC_busy,
    output logic                  CDO_PV_upt1,
    output logic [W_PD_DATA-1:0]  CDO_PD_upt1,
    output logic [W_PA_REG-1:0]   CDO_PA_upt1,
    output logic [W_AA_INSTR-1:0] DFO_AA_pc
);

    import resv_exec_pkg::*;

    exec_state_t state, next_state;

    logic [2:0]             cls;
    logic [2:0]             func;
    logic                   issue;
    logic                   alu_issue;
    logic                   mul_start;
    logic                   mul_done;
    logic [2*W_PD_DATA-1:0] mul_product;
    logic [W_PD_DATA-1:0]   alu_b;
    logic [W_PD_DATA-1:0]   alu_result;
    logic [W_PA_REG-1:0]    mul_rd;
    logic [W_AA_INSTR-1:0]  mul_pc;
    logic                   mul_hi;

    always_comb begin
        cls       = DFI_PD_uops[W_PD_UOPS-1 -: 3];
        func      = DFI_PD_uops[2:0];
        issue     = DFI_PC_valid && !CFO_PC_busy && !CFI_PC_clear && (DFI_PD_uops != unused_op);
        alu_issue = issue && ((cls == CLS_ALUI) || (cls == CLS_ALUR));
        mul_start = issue && (cls == CLS_MUL);
    end

    always_comb begin
        alu_b      = (cls == CLS_ALUI) ? DFI_PD_imm : DFI_PD_rt;
        alu_result = '0;
        case (func)
            FN_ADD:  alu_result = DFI_PD_rs + alu_b;
            FN_SUB:  alu_result = DFI_PD_rs - alu_b;
            FN_AND:  alu_result = DFI_PD_rs & alu_b;
            FN_OR:   alu_result = DFI_PD_rs | alu_b;
            FN_XOR:  alu_result = DFI_PD_rs ^ alu_b;
            FN_SLL:  alu_result = DFI_PD_rs << alu_b[4:0];
            FN_SRL:  alu_result = DFI_PD_rs >> alu_b[4:0];
            FN_SLT:  alu_result = {{(W_PD_DATA-1){1'b0}}, ($signed(DFI_PD_rs) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
    end

    iter_mul #(
        .W(W_PD_DATA)
    ) u_iter_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .abort  (CFI_PC_clear),
        .a      (DFI_PD_rs),
        .b      (DFI_PD_rt),
        .done   (mul_done),
        .product(mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (CFI_PC_clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (mul_start) next_state = MUL;
                MUL:     if (mul_done)  next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        CFO_PC_busy = (state != IDLE);
    end

    // The multiply's destination and pc are held here since the station moves on after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_rd <= '0;
            mul_pc <= '0;
            mul_hi <= 1'b0;
        end else if (mul_start) begin
            mul_rd <= DFI_PA_rd;
            mul_pc <= DFI_AA_pc;
            mul_hi <= (func == FN_MUL_HI);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            CDO_PV_upt1 <= 1'b0;
            CDO_PD_upt1 <= '0;
            CDO_PA_upt1 <= '0;
            DFO_AA_pc   <= '0;
        end else begin
            CDO_PV_upt1 <= 1'b0;
            if (alu_issue) begin
                CDO_PV_upt1 <= (DFI_PA_rd != '0);
                CDO_PD_upt1 <= alu_result;
                CDO_PA_upt1 <= DFI_PA_rd;
                DFO_AA_pc   <= DFI_AA_pc;
            end else if ((state == MUL) && mul_done && !CFI_PC_clear) begin
                CDO_PV_upt1 <= (mul_rd != '0);
                CDO_PD_upt1 <= mul_hi ? mul_product[2*W_PD_DATA-1:W_PD_DATA]
                                      : mul_product[W_PD_DATA-1:0];
                CDO_PA_upt1 <= mul_rd;
                DFO_AA_pc   <= mul_pc;
            end
        end
    end

endmodule

// File: tb/tb_resv_exec_unit.sv
// Bench for resv_exec_unit: directed cases plus random issue traffic, compared each
// cycle against a behavioural model tracking busy time and the pending broadcast.
module tb_resv_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [5:0]  uops = 6'h3F;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic [31:0] imm = '0;
    logic [4:0]  rd = '0;
    logic [31:0] pc = '0;
    logic        clear = 1'b0;
    logic        busy;
    logic        upt_v;
    logic [31:0] upt_d;
    logic [4:0]  upt_a;
    logic [31:0] upt_pc;

    int tests = 0;
    int failures = 0;

    // Model state: busy cycles left, the pending multiply result, and expected outputs this cycle.
    int          m_left = 0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_pc = '0;
    logic        exp_v = 1'b0;
    logic [31:0] exp_d = '0;
    logic [4:0]  exp_a = '0;
    logic [31:0] exp_pc = '0;

    resv_exec_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .DFI_PC_valid(valid),
        .DFI_PD_uops (uops),
        .DFI_PD_rs   (rs),
        .DFI_PD_rt   (rt),
        .DFI_PD_imm  (imm),
        .DFI_PA_rd   (rd),
        .DFI_AA_pc   (pc),
        .CFI_PC_clear(clear),
        .CFO_PC_busy (busy),
        .CDO_PV_upt1 (upt_v),
        .CDO_PD_upt1 (upt_d),
        .CDO_PA_upt1 (upt_a),
        .DFO_AA_pc   (upt_pc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] aluRef(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << (b % 32);
            3'd6:    return a >> (b % 32);
            default: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mulRef(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return (f == 3'd1) ? p[63:32] : p[31:0];
    endfunction

    task automatic compareAll();
        checkOutput("busy", 64'(busy), 64'(m_left > 0));
        checkOutput("upt_valid", 64'(upt_v), 64'(exp_v));
        if (exp_v) begin
            checkOutput("upt_data", 64'(upt_d), 64'(exp_d));
            checkOutput("upt_rd", 64'(upt_a), 64'(exp_a));
            checkOutput("upt_pc", 64'(upt_pc), 64'(exp_pc));
        end
    endtask

    // Advance the model across the coming rising edge using the inputs now being driven.
    task automatic modelStep();
        logic accept;
        logic [2:0] c;
        c      = uops[5:3];
        accept = valid && (m_left == 0) && !clear && (uops != 6'h3F);
        exp_v  = 1'b0;
        if (clear) begin
            m_left = 0;
        end else if (m_left > 0) begin
            if (m_left == 2) begin
                exp_v  = (m_rd != 0);
                exp_d  = m_res;
                exp_a  = m_rd;
                exp_pc = m_pc;
            end
            m_left--;
        end else if (accept) begin
            if (c == 3'd0 || c == 3'd1) begin
                exp_v  = (rd != 0);
                exp_d  = aluRef(uops[2:0], rs, (c == 3'd0) ? imm : rt);
                exp_a  = rd;
                exp_pc = pc;
            end else if (c == 3'd2) begin
                m_left = 33;
                m_res  = mulRef(uops[2:0], rs, rt);
                m_rd   = rd;
                m_pc   = pc;
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] u, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] im, input logic [4:0] d,
                                 input logic [31:0] p, input logic clr);
        @(negedge clk);
        compareAll();
        valid = v;
        uops  = u;
        rs    = a;
        rt    = b;
        imm   = im;
        rd    = d;
        pc    = p;
        clear = clr;
        modelStep();
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_valid", 64'(upt_v), 64'd0);
        checkOutput("rst_data", 64'(upt_d), 64'd0);
        checkOutput("rst_rd", 64'(upt_a), 64'd0);
        checkOutput("rst_pc", 64'(upt_pc), 64'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        m_left = 0;
        exp_v  = 1'b0;
        valid  = 1'b0;
        clear  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0]  u;
        logic [2:0]  cls;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  d;
        int          r;

        #1;
        checkResetOutputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed ALU cases
        applyStimulus(1'b1, 6'h08, 32'd5, 32'd7, 32'd0, 5'd3, 32'h100, 1'b0);
        applyStimulus(1'b1, 6'h01, 32'd5, 32'd0, 32'd7, 5'd4, 32'h104, 1'b0);
        applyStimulus(1'b1, 6'h0F, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd5, 32'h108, 1'b0);
        applyStimulus(1'b1, 6'h0D, 32'd1, 32'd33, 32'd0, 5'd6, 32'h10C, 1'b0);
        applyStimulus(1'b1, 6'h08, 32'd9, 32'd9, 32'd0, 5'd0, 32'h110, 1'b0);
        applyStimulus(1'b1, 6'h3F, 32'd1, 32'd1, 32'd0, 5'd7, 32'h114, 1'b0);
        applyStimulus(1'b1, 6'h08, 32'd1, 32'd2, 32'd0, 5'd8, 32'h118, 1'b1);
        idleCycles(2);

        // Multiplies with a dependent ADD held by the station while busy
        for (int f = 0; f < 2; f++) begin
            applyStimulus(1'b1, 6'h10 | 6'(f), 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd9, 32'h200, 1'b0);
            idleCycles(4);
            for (int k = 0; k < 32; k++) begin
                applyStimulus(1'b1, 6'h08, 32'd3, 32'd4, 32'd0, 5'd10, 32'h204, 1'b0);
            end
            idleCycles(2);
        end

        applyStimulus(1'b1, 6'h10, 32'd1234, 32'd5678, 32'd0, 5'd0, 32'h300, 1'b0);
        idleCycles(36);

        applyStimulus(1'b1, 6'h11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'd0, 5'd11, 32'h400, 1'b0);
        idleCycles(9);
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1);
        idleCycles(30);

        // Reset while a multiply is in flight
        applyStimulus(1'b1, 6'h10, 32'd77, 32'd3, 32'd0, 5'd12, 32'h500, 1'b0);
        idleCycles(6);
        doReset();
        idleCycles(3);

        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      cls = 3'd1;
            else if (r <= 6) cls = 3'd0;
            else if (r == 7) cls = 3'd2;
            else             cls = 3'($urandom_range(3, 7));
            u = {cls, 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 19) == 0) u = 6'h3F;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if (i == 1200) begin
                doReset();
            end
            applyStimulus($urandom_range(0, 3) != 0, u, a, b, $urandom, d, $urandom,
                          $urandom_range(0, 39) == 0);
        end
        idleCycles(40);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
